dm_sba_bridge: RTL and testbench
================================

DM_SBA_BRIDGE -- requirements
Module: dm_sba_bridge

Interface
REQ-001 Parameters:
- BusWidth, 32, data/address width; 32 or 64 only.
- TimeoutCycles, 256, cycle budget per transaction; 0 disables the timeout.

REQ-002 One clock; reset is synchronous and active-high.

REQ-003 Ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- dmactive_i, in, 1, debug module active; low blocks new acceptances.
- slv_req_i, in, 1, request from the SBA master.
- slv_add_i, in, BusWidth, address.
- slv_we_i, in, 1, write enable.
- slv_wdata_i, in, BusWidth, write data.
- slv_be_i, in, BusWidth/8, byte enables.
- slv_gnt_o, out, 1, request accepted.
- slv_r_valid_o, out, 1, response valid, for reads and writes.
- slv_r_rdata_o, out, BusWidth, read data.
- slv_err_o, out, 1, response carries an error; valid with slv_r_valid_o.
- mst_req_o, out, 1, system bus request.
- mst_add_o, out, BusWidth, system bus address.
- mst_we_o, out, 1, system bus write enable.
- mst_wdata_o, out, BusWidth, system bus write data.
- mst_be_o, out, BusWidth/8, system bus byte enables.
- mst_gnt_i, in, 1, system bus grant.
- mst_r_valid_i, in, 1, system bus response valid.
- mst_r_rdata_i, in, BusWidth, system bus read data.
- mst_r_err_i, in, 1, system bus error; valid with mst_r_valid_i.
- timeout_o, out, 1, one-cycle pulse when a timeout fires.

Function
REQ-004 The FSM shall have states Idle, Req, Wait and Resp; the state register, a stale flag and a timeout counter shall be the only control state.

REQ-005 Idle: slv_gnt_o = slv_req_i & dmactive_i & !stale. On a grant, add/we/wdata/be shall be captured into registers and the FSM shall move to Req.

REQ-006 Req: mst_req_o shall be 1 and the mst_* fields shall be driven only from the captured registers. On mst_gnt_i the FSM shall move to Wait. The captured fields shall stay stable until the grant.

REQ-007 Wait: on mst_r_valid_i, the bridge shall capture rdata (forced to 0 when we=1) and err=mst_r_err_i, then move to Resp.

REQ-008 Resp: slv_r_valid_o shall be 1 for exactly one cycle with the registered rdata/err, and the FSM shall then return to Idle. slv_gnt_o shall be 0 in Resp.

REQ-009 Minimum latency: grant at cycle N, mst_req_o at N+1, with mst_gnt_i at N+1 and mst_r_valid_i at N+2 giving slv_r_valid_o at N+3. Back-to-back: a new grant is possible at N+4.

REQ-010 Timeout counter behaviour:
- Cleared on entry to Req.
- Increments every cycle in Req and Wait.
- Saturates, with no wrap-around.

REQ-011 Timeout firing (TimeoutCycles>0): if the counter equals TimeoutCycles-1 and the state's advancing event (mst_gnt_i in Req, mst_r_valid_i in Wait) is absent, the FSM shall go to Resp with err=1 and rdata=0, and timeout_o shall pulse. An advancing event in that same cycle shall win over the timeout.

REQ-012 A timeout in Wait shall set stale. A timeout in Req shall drop mst_req_o without setting stale.

REQ-013 While stale=1, the next mst_r_valid_i shall be consumed and discarded and shall clear stale; no slv_r_valid_o shall result.

REQ-014 mst_r_valid_i arriving in Idle with stale=0, or in Req, shall be ignored.

REQ-015 dmactive_i low shall only block new grants; an in-flight transaction shall complete or time out normally.

REQ-016 slv_r_rdata_o shall hold its value outside Resp; only slv_r_valid_o qualifies it.

Reset
REQ-017 When rst_i=1 at a clock edge, all registers shall take their reset values:
- State: Idle.
- stale: 0.
- Counter: 0.
- Captured fields and response registers: 0.
- Outputs: slv_gnt_o, slv_r_valid_o, slv_err_o, mst_req_o, mst_we_o and timeout_o all 0.

REQ-018 Reset mid-transaction shall abandon the transaction without generating a response. stale shall not be set by a reset.

Verification
REQ-019 Read: req with add=0x1000, be=0xF; gnt next cycle; r_valid 1 cycle later with rdata=0xDEADBEEF -> slv_r_valid_o pulses at N+3 with 0xDEADBEEF, err=0.

REQ-020 Write with grant delayed 5 cycles: mst_req_o and mst_add/wdata/be are stable for all 5 cycles; response has rdata=0, err=0.

REQ-021 Bus error: mst_r_err_i=1 with r_valid -> slv_err_o=1 together with slv_r_valid_o.

REQ-022 Timeout with TimeoutCycles=8:
- No r_valid after the grant -> timeout_o pulse and slv_r_valid_o with err=1 exactly 8 cycles after entering Req.
- A late r_valid is dropped, and the next request is granted only after that drop.

REQ-023 Boundary: mst_gnt_i exactly at cycle TimeoutCycles-1 -> no timeout.

REQ-024 Reset during Wait -> Idle next cycle, no slv_r_valid_o. dmactive_i=0 with slv_req_i=1 -> slv_gnt_o stays 0.

Source files
------------

// File: rtl/dm_sba_bridge.sv
// dm_sba_bridge: carries one SBA access at a time onto a req/gnt + r_valid system
// bus. A per-transaction watchdog turns a stuck access into an error response.
// A response that arrives after its transaction timed out is discarded.
module dm_sba_bridge #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dmactive_i,
  input  logic                  slv_req_i,
  input  logic [BusWidth-1:0]   slv_add_i,
  input  logic                  slv_we_i,
  input  logic [BusWidth-1:0]   slv_wdata_i,
  input  logic [BusWidth/8-1:0] slv_be_i,
  output logic                  slv_gnt_o,
  output logic                  slv_r_valid_o,
  output logic [BusWidth-1:0]   slv_r_rdata_o,
  output logic                  slv_err_o,
  output logic                  mst_req_o,
  output logic [BusWidth-1:0]   mst_add_o,
  output logic                  mst_we_o,
  output logic [BusWidth-1:0]   mst_wdata_o,
  output logic [BusWidth/8-1:0] mst_be_o,
  input  logic                  mst_gnt_i,
  input  logic                  mst_r_valid_i,
  input  logic [BusWidth-1:0]   mst_r_rdata_i,
  input  logic                  mst_r_err_i,
  output logic                  timeout_o
);

  if (BusWidth != 32 && BusWidth != 64) begin : g_bad_bus_width
    $error("dm_sba_bridge: BusWidth must be 32 or 64");
  end

  // The counter saturates at TimeoutCycles-1, which is the firing value, so it
  // stays at the firing value once reached. With the timeout disabled it simply
  // saturates at its maximum and is never compared.
  localparam int unsigned CntWidth = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles);
  localparam int unsigned SatVal   = (TimeoutCycles == 0) ? ((1 << CntWidth) - 1)
                                                          : (TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] CntSat = CntWidth'(SatVal);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  stale_q, stale_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic [BusWidth-1:0]   add_q;
  logic                  we_q;
  logic [BusWidth-1:0]   wdata_q;
  logic [BusWidth/8-1:0] be_q;
  logic [BusWidth-1:0]   rdata_q;
  logic                  err_q;
  logic                  timeout_q;

  logic                  capture;
  logic                  resp_load;
  logic [BusWidth-1:0]   resp_rdata;
  logic                  resp_err;
  logic                  tmo_fire;
  logic                  tmo_hit;
  logic [CntWidth-1:0]   cnt_inc;

  assign tmo_hit = (TimeoutCycles != 0) && (cnt_q == CntSat);
  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + CntWidth'(1);

  // Next-state, watchdog and stale-flag decisions for the transaction FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    stale_d    = stale_q;
    cnt_d      = cnt_q;
    slv_gnt_o  = 1'b0;
    capture    = 1'b0;
    resp_load  = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    tmo_fire   = 1'b0;

    // A late response from a timed-out access is swallowed whatever the state.
    if (stale_q && mst_r_valid_i) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        slv_gnt_o = slv_req_i & dmactive_i & ~stale_q;
        if (slv_gnt_o) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        if (mst_gnt_i) begin
          state_d = StWait;
        end else if (tmo_hit) begin
          // Nothing is outstanding on the bus yet, so no late response can follow.
          state_d   = StResp;
          resp_load = 1'b1;
          resp_err  = 1'b1;
          tmo_fire  = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (mst_r_valid_i) begin
          state_d    = StResp;
          resp_load  = 1'b1;
          resp_rdata = we_q ? '0 : mst_r_rdata_i;
          resp_err   = mst_r_err_i;
        end else if (tmo_hit) begin
          // The bus still owes a response; mark it so it is discarded later.
          state_d   = StResp;
          resp_load = 1'b1;
          resp_err  = 1'b1;
          tmo_fire  = 1'b1;
          stale_d   = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state: FSM state, stale flag and watchdog counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst_i) begin
      state_q <= StIdle;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  // Captured request fields, response registers and the timeout pulse.
  always_ff @(posedge clk_i) begin
    // NOTE: the payload registers are reset as well, so the bus outputs are
    // defined zeros after reset rather than X.
    if (rst_i) begin
      add_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_fire;
      if (capture) begin
        add_q   <= slv_add_i;
        we_q    <= slv_we_i;
        wdata_q <= slv_wdata_i;
        be_q    <= slv_be_i;
      end
      if (resp_load) begin
        rdata_q <= resp_rdata;
        err_q   <= resp_err;
      end
    end
  end

  assign slv_r_valid_o = (state_q == StResp);
  assign slv_r_rdata_o = rdata_q;
  assign slv_err_o     = err_q;
  assign mst_req_o     = (state_q == StReq);
  assign mst_add_o     = add_q;
  assign mst_we_o      = we_q;
  assign mst_wdata_o   = wdata_q;
  assign mst_be_o      = be_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_dm_sba_bridge.sv
// tb_dm_sba_bridge: randomized scoreboard bench for dm_sba_bridge with an 8-cycle
// timeout. The driver predicts each response from the bus timing it will apply,
// and a monitor checks the DUT's responses against those predictions.
module tb_dm_sba_bridge;

  localparam int unsigned BW = 32;
  localparam int          TC = 8;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          dmactive_i;
  logic          slv_req_i;
  logic [BW-1:0] slv_add_i;
  logic          slv_we_i;
  logic [BW-1:0] slv_wdata_i;
  logic [3:0]    slv_be_i;
  logic          slv_gnt_o;
  logic          slv_r_valid_o;
  logic [BW-1:0] slv_r_rdata_o;
  logic          slv_err_o;
  logic          mst_req_o;
  logic [BW-1:0] mst_add_o;
  logic          mst_we_o;
  logic [BW-1:0] mst_wdata_o;
  logic [3:0]    mst_be_o;
  logic          mst_gnt_i;
  logic          mst_r_valid_i;
  logic [BW-1:0] mst_r_rdata_i;
  logic          mst_r_err_i;
  logic          timeout_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          free_cyc = 0;
  int          tmo_exp  = 0;
  int          tmo_seen = 0;
  logic [31:0] hold_exp = '0;
  exp_t        exp_q[$];

  dm_sba_bridge #(.BusWidth(BW), .TimeoutCycles(TC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dmactive_i   (dmactive_i),
    .slv_req_i    (slv_req_i),
    .slv_add_i    (slv_add_i),
    .slv_we_i     (slv_we_i),
    .slv_wdata_i  (slv_wdata_i),
    .slv_be_i     (slv_be_i),
    .slv_gnt_o    (slv_gnt_o),
    .slv_r_valid_o(slv_r_valid_o),
    .slv_r_rdata_o(slv_r_rdata_o),
    .slv_err_o    (slv_err_o),
    .mst_req_o    (mst_req_o),
    .mst_add_o    (mst_add_o),
    .mst_we_o     (mst_we_o),
    .mst_wdata_o  (mst_wdata_o),
    .mst_be_o     (mst_be_o),
    .mst_gnt_i    (mst_gnt_i),
    .mst_r_valid_i(mst_r_valid_i),
    .mst_r_rdata_i(mst_r_rdata_i),
    .mst_r_err_i  (mst_r_err_i),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble_slv();
    slv_add_i   = $urandom;
    slv_we_i    = 1'($urandom_range(0, 1));
    slv_wdata_i = $urandom;
    slv_be_i    = 4'($urandom_range(0, 15));
  endtask

  // One SBA access. g = stall cycles before mst_gnt_i (counted from the first
  // Req cycle), r = cycles after the bus grant before mst_r_valid_i.
  task automatic do_txn(input logic we, input logic [31:0] add, input logic [31:0] wd,
                        input logic [3:0] be, input int g, input int r,
                        input logic [31:0] rd, input logic er);
    int   issue, n, e, kf, kr, waited;
    exp_t x;
    issue       = cyc;
    dmactive_i  = 1'b1;
    slv_req_i   = 1'b1;
    slv_we_i    = we;
    slv_add_i   = add;
    slv_wdata_i = wd;
    slv_be_i    = be;
    waited      = 0;
    @(negedge clk_i);
    while (!slv_gnt_o && waited < 64) begin
      next_cycle();
      waited++;
      @(negedge clk_i);
    end
    if (!slv_gnt_o) begin
      check("grant_wait", slv_gnt_o, 1);
      slv_req_i = 1'b0;
      next_cycle();
      return;
    end
    n = cyc;
    check("grant_cycle", n, (issue > free_cyc) ? issue : free_cyc);

    // Reference model: the watchdog counts Req+Wait cycles from 0 and fires at the
    // first cycle index >= TC-1 whose advancing event is missing.
    e       = n + 1;
    x.tmo   = 1'b0;
    x.rdata = we ? 32'h0 : rd;
    x.err   = er;
    kf      = 0;
    kr      = 0;
    if (g >= TC) begin
      x.tmo = 1'b1; x.rdata = '0; x.err = 1'b1;
      x.cyc    = e + TC;
      free_cyc = e + TC + 1;
    end else begin
      kf = (g + 1 > TC - 1) ? g + 1 : TC - 1;
      kr = g + 1 + r;
      if (kr <= kf) begin
        x.cyc    = e + kr + 1;
        free_cyc = e + kr + 2;
      end else begin
        x.tmo = 1'b1; x.rdata = '0; x.err = 1'b1;
        x.cyc    = e + kf + 1;
        free_cyc = e + kr + 1;
      end
    end
    exp_q.push_back(x);
    if (x.tmo) tmo_exp++;

    next_cycle();
    slv_req_i = 1'b0;
    for (int k = 0; k <= g && k < TC; k++) begin
      scramble_slv();
      mst_gnt_i     = (k == g);
      mst_r_valid_i = ($urandom_range(0, 3) == 0);
      mst_r_rdata_i = $urandom;
      mst_r_err_i   = 1'($urandom_range(0, 1));
      dmactive_i    = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      check("mst_req_hold", mst_req_o, 1);
      check("mst_add", mst_add_o, add);
      check("mst_we", mst_we_o, we);
      check("mst_wdata", mst_wdata_o, wd);
      check("mst_be", mst_be_o, be);
      next_cycle();
    end
    mst_gnt_i     = 1'b0;
    mst_r_valid_i = 1'b0;
    if (g >= TC) begin
      @(negedge clk_i);
      check("mst_req_drop", mst_req_o, 0);
      next_cycle();
      return;
    end
    for (int j = 0; j <= r; j++) begin
      mst_r_valid_i = (j == r);
      mst_r_rdata_i = rd;
      mst_r_err_i   = er;
      if (kr > kf && g + 1 + j > kf) begin
        // Timed out: a new request must wait until the late response is dropped.
        slv_req_i  = 1'b1;
        dmactive_i = 1'b1;
        scramble_slv();
        @(negedge clk_i);
        check("gnt_blocked_stale", slv_gnt_o, 0);
      end else begin
        dmactive_i = 1'($urandom_range(0, 1));
      end
      next_cycle();
    end
    mst_r_valid_i = 1'b0;
  endtask

  // Monitor: checks every response against the head of the scoreboard queue.
  initial begin
    exp_t mx;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (timeout_o) tmo_seen++;
        if (slv_r_valid_o) begin
          check("gnt_in_resp", slv_gnt_o, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_resp", slv_r_valid_o, 0);
          end else begin
            mx = exp_q.pop_front();
            check("resp_cycle", cyc, mx.cyc);
            check("resp_rdata", slv_r_rdata_o, mx.rdata);
            check("resp_err", slv_err_o, mx.err);
            check("resp_timeout", timeout_o, mx.tmo);
            hold_exp = mx.rdata;
          end
        end else begin
          check("rdata_hold", slv_r_rdata_o, hold_exp);
          check("timeout_without_resp", timeout_o, 0);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: run exceeded 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i         = 1'b1;
    dmactive_i    = 1'b1;
    slv_req_i     = 1'b0;
    slv_add_i     = '0;
    slv_we_i      = 1'b0;
    slv_wdata_i   = '0;
    slv_be_i      = '0;
    mst_gnt_i     = 1'b0;
    mst_r_valid_i = 1'b0;
    mst_r_rdata_i = '0;
    mst_r_err_i   = 1'b0;
    repeat (3) next_cycle();
    rst_i    = 1'b0;
    free_cyc = cyc;
    @(negedge clk_i);
    check("rst_gnt", slv_gnt_o, 0);
    check("rst_r_valid", slv_r_valid_o, 0);
    check("rst_err", slv_err_o, 0);
    check("rst_mst_req", mst_req_o, 0);
    check("rst_mst_we", mst_we_o, 0);
    check("rst_mst_add", mst_add_o, 0);
    check("rst_timeout", timeout_o, 0);
    next_cycle();

    // Directed: minimum-latency read, stalled write, bus error.
    do_txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, 5, 0, 32'h1234_5678, 1'b0);
    do_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 1, 2, 32'h5555_AAAA, 1'b1);
    // Timeout in Wait with a late response, then one that queues behind it.
    do_txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 12, 32'hBAD0_BAD0, 1'b0);
    do_txn(1'b0, 32'h0000_4004, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D, 1'b0);
    // Timeout in Req, then grant/response boundaries around TC-1.
    do_txn(1'b1, 32'h0000_5000, 32'h1111_2222, 4'hC, 10, 0, 32'h0, 1'b0);
    do_txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, TC - 1, 0, 32'h7777_0001, 1'b0);
    do_txn(1'b0, 32'h0000_6004, 32'h0, 4'hF, TC - 1, 1, 32'h7777_0002, 1'b0);
    do_txn(1'b0, 32'h0000_6008, 32'h0, 4'hF, TC - 2, 0, 32'h7777_0003, 1'b0);
    do_txn(1'b0, 32'h0000_600C, 32'h0, 4'hF, TC - 2, 1, 32'h7777_0004, 1'b0);

    // dmactive low blocks new grants.
    dmactive_i = 1'b0;
    slv_req_i  = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("gnt_dmactive_low", slv_gnt_o, 0);
      next_cycle();
    end
    slv_req_i  = 1'b0;
    dmactive_i = 1'b1;

    // Reset while waiting for the bus response abandons the access silently.
    slv_req_i = 1'b1;
    slv_add_i = 32'h0000_7000;
    @(negedge clk_i);
    check("rst_txn_gnt", slv_gnt_o, 1);
    next_cycle();
    slv_req_i = 1'b0;
    mst_gnt_i = 1'b1;
    next_cycle();
    mst_gnt_i = 1'b0;
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i         = 1'b0;
    hold_exp      = '0;
    mst_r_valid_i = 1'b1;
    mst_r_rdata_i = 32'hFEED_FACE;
    @(negedge clk_i);
    check("rst_wait_idle", mst_req_o, 0);
    check("rst_wait_no_resp", slv_r_valid_o, 0);
    next_cycle();
    mst_r_valid_i = 1'b0;
    free_cyc      = cyc;

    for (int t = 0; t < 150; t++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 10), $urandom_range(0, 10), $urandom,
             1'($urandom_range(0, 1)));
    end

    slv_req_i = 1'b0;
    repeat (20) next_cycle();
    check("queue_drained", exp_q.size(), 0);
    check("timeout_count", tmo_seen, tmo_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
